fwd_hazard_unit: RTL

Parametrised forwarding and hazard unit for the 5-stage pipeline. It supersedes the fixed two-operand forwarding control. It tracks in-flight register writers in EX, MEM and WB in an internal scoreboard. From that it produces:
- registered EX-stage forward selects,
- combinational ID-stage (early/branch) forward selects,
- load-use and early-operand stalls,
- a whole-pipeline freeze while a data-memory access waits on its ready handshake.

---
 rtl/fwd_pkg.sv | 26 ++
 rtl/fwd_hazard_unit_resolve.sv | 59 +++++
 rtl/fwd_hazard_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types and select encodings for the forwarding/hazard unit.
// Selects are 2-bit codes; scoreboard entries describe one in-flight instruction.
package fwd_pkg;

  // Widest register address an entry can hold; REG_AW must not exceed this.
  localparam int FWD_DST_W = 8;

  localparam logic [1:0] FWD_EX_RF        = 2'b00;
  localparam logic [1:0] FWD_EX_EXMEM_ALU = 2'b01;
  localparam logic [1:0] FWD_EX_MEMWB_ALU = 2'b10;
  localparam logic [1:0] FWD_EX_MEMWB_LD  = 2'b11;

  localparam logic [1:0] FWD_ID_RF    = 2'b00;
  localparam logic [1:0] FWD_ID_EXMEM = 2'b01;
  localparam logic [1:0] FWD_ID_MEMWB = 2'b10;

  typedef struct packed {
    logic                 valid;
    logic [FWD_DST_W-1:0] dst;
    logic                 is_load;
    logic                 is_mem;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, dst: '0, is_load: 1'b0, is_mem: 1'b0};

endpackage

// File: rtl/fwd_hazard_unit_resolve.sv
// fwd_src_resolve: priority resolver for one source operand against the
// EX/MEM/WB scoreboard entries; youngest matching writer wins.
module fwd_src_resolve
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_reg_i,
  input  logic              src_used_i,
  input  logic              src_early_i,
  input  logic              ex_vld_i,
  input  logic [REG_AW-1:0] ex_dst_i,
  input  logic              ex_load_i,
  input  logic              mem_vld_i,
  input  logic [REG_AW-1:0] mem_dst_i,
  input  logic              mem_load_i,
  input  logic              wb_vld_i,
  input  logic [REG_AW-1:0] wb_dst_i,
  output logic [1:0]        sel_ex_o,
  output logic [1:0]        sel_id_o,
  output logic              hazard_o
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  // Stores carry dst=0, so a zero dst never matches (x0 is not tracked).
  assign ex_hit  = ex_vld_i  && (ex_dst_i  != '0) && (ex_dst_i  == src_reg_i);
  assign mem_hit = mem_vld_i && (mem_dst_i != '0) && (mem_dst_i == src_reg_i);
  assign wb_hit  = wb_vld_i  && (wb_dst_i  != '0) && (wb_dst_i  == src_reg_i);

  always_comb begin
    sel_ex_o = FWD_EX_RF;
    sel_id_o = FWD_ID_RF;
    hazard_o = 1'b0;
    if (src_used_i) begin
      if (!src_early_i) begin
        if (ex_hit) begin
          if (ex_load_i) hazard_o = 1'b1;
          else           sel_ex_o = FWD_EX_EXMEM_ALU;
        end else if (mem_hit) begin
          sel_ex_o = mem_load_i ? FWD_EX_MEMWB_LD : FWD_EX_MEMWB_ALU;
        end
      end else begin
        // Early consumers compare in ID, so any EX writer is still too young.
        if (ex_hit) begin
          hazard_o = 1'b1;
        end else if (mem_hit) begin
          if (mem_load_i) hazard_o = 1'b1;
          else            sel_id_o = FWD_ID_EXMEM;
        end else if (wb_hit) begin
          sel_id_o = FWD_ID_MEMWB;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: EX/MEM/WB writer scoreboard, registered EX selects,
// combinational ID selects, stalls and memory freeze. Counters under FWD_PERF_CNT_EN.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_reg,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [NUM_SRC-1:0]        id_src_early,
  input  logic [REG_AW-1:0]         id_dst_reg,
  input  logic                      id_wen,
  input  logic                      id_is_load,
  input  logic                      id_is_mem,
  input  logic                      mem_ready,
  input  logic                      flush,
  output logic                      stall_if_id,
  output logic                      bubble_ex,
  output logic                      freeze,
  output logic [NUM_SRC*2-1:0]      fwd_sel_ex,
  output logic [NUM_SRC*2-1:0]      fwd_sel_id
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]          cnt_stall,
  output logic [CNT_W-1:0]          cnt_bubble,
  output logic [CNT_W-1:0]          cnt_freeze
`endif
);

  sb_entry_t ex_q, ex_d;
  sb_entry_t mem_q, mem_d;
  sb_entry_t wb_q, wb_d;
  sb_entry_t id_entry;

  logic [NUM_SRC*2-1:0] fwd_sel_ex_q, fwd_sel_ex_d;
  logic [NUM_SRC*2-1:0] sel_ex_w;
  logic [NUM_SRC*2-1:0] sel_id_w;
  logic [NUM_SRC-1:0]   src_haz_w;
  logic                 hazard_w;
  logic                 freeze_w;
  logic                 unused_sb;

  // Non-writers record dst=0 so only stores (is_mem) keep a dst-less entry alive.
  always_comb begin
    id_entry         = SB_EMPTY;
    id_entry.valid   = id_valid && ((id_wen && (id_dst_reg != '0)) || id_is_mem);
    id_entry.dst     = id_wen ? FWD_DST_W'(id_dst_reg) : '0;
    id_entry.is_load = id_is_load;
    id_entry.is_mem  = id_is_mem;
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_src_resolve #(.REG_AW(REG_AW)) u_resolve (
      .src_reg_i   (id_src_reg[g*REG_AW +: REG_AW]),
      .src_used_i  (id_src_used[g]),
      .src_early_i (id_src_early[g]),
      .ex_vld_i    (ex_q.valid),
      .ex_dst_i    (ex_q.dst[REG_AW-1:0]),
      .ex_load_i   (ex_q.is_load),
      .mem_vld_i   (mem_q.valid),
      .mem_dst_i   (mem_q.dst[REG_AW-1:0]),
      .mem_load_i  (mem_q.is_load),
      .wb_vld_i    (wb_q.valid),
      .wb_dst_i    (wb_q.dst[REG_AW-1:0]),
      .sel_ex_o    (sel_ex_w[g*2 +: 2]),
      .sel_id_o    (sel_id_w[g*2 +: 2]),
      .hazard_o    (src_haz_w[g])
    );
  end

  assign hazard_w = id_valid && (|src_haz_w);
  assign freeze_w = mem_q.valid && mem_q.is_mem && !mem_ready;

  assign stall_if_id = freeze_w | hazard_w;
  assign bubble_ex   = hazard_w & ~freeze_w;
  assign freeze      = freeze_w;
  assign fwd_sel_ex  = fwd_sel_ex_q;
  assign fwd_sel_id  = sel_id_w;

  assign unused_sb = ^{ex_q, mem_q, wb_q};

  always_comb begin
    ex_d         = ex_q;
    mem_d        = mem_q;
    wb_d         = wb_q;
    fwd_sel_ex_d = fwd_sel_ex_q;
    if (!freeze_w) begin
      mem_d = ex_q;
      wb_d  = mem_q;
      if (flush || hazard_w) begin
        ex_d         = SB_EMPTY;
        fwd_sel_ex_d = '0;
      end else begin
        ex_d         = id_entry;
        fwd_sel_ex_d = id_valid ? sel_ex_w : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q         <= SB_EMPTY;
      mem_q        <= SB_EMPTY;
      wb_q         <= SB_EMPTY;
      fwd_sel_ex_q <= '0;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      fwd_sel_ex_q <= fwd_sel_ex_d;
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_stall_q,  cnt_stall_d;
  logic [CNT_W-1:0] cnt_bubble_q, cnt_bubble_d;
  logic [CNT_W-1:0] cnt_freeze_q, cnt_freeze_d;

  // Saturating increments: hold once all-ones is reached.
  always_comb begin
    cnt_stall_d  = cnt_stall_q;
    cnt_bubble_d = cnt_bubble_q;
    cnt_freeze_d = cnt_freeze_q;
    if (hazard_w && !freeze_w && (cnt_stall_q != '1))
      cnt_stall_d = cnt_stall_q + 1'b1;
    if ((flush || hazard_w) && !freeze_w && (cnt_bubble_q != '1))
      cnt_bubble_d = cnt_bubble_q + 1'b1;
    if (freeze_w && (cnt_freeze_q != '1))
      cnt_freeze_d = cnt_freeze_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_stall_q  <= '0;
      cnt_bubble_q <= '0;
      cnt_freeze_q <= '0;
    end else begin
      cnt_stall_q  <= cnt_stall_d;
      cnt_bubble_q <= cnt_bubble_d;
      cnt_freeze_q <= cnt_freeze_d;
    end
  end

  assign cnt_stall  = cnt_stall_q;
  assign cnt_bubble = cnt_bubble_q;
  assign cnt_freeze = cnt_freeze_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule
